sync_fifo: RTL and testbench
============================

# sync_fifo

Synchronous first-in/first-out buffer built around the lab's dual-port RAM. The FIFO owns the write and read pointers, so the RAM is driven as a streaming queue instead of by explicit addresses. Upstream logic pushes bytes with `write` and downstream logic pops them with `read`. Full, empty, occupancy and error flags give both sides a simple handshake in a single clock domain.

## Interface
- `width`, 8: data word width in bits.
- `depth`, 16: number of entries; must equal 2**`addr`.
- `addr`, 4: pointer and address width.

- `clk`  input  1: rising-edge clock.
- `reset`  input  1: asynchronous, active-low reset.
- `write`  input  1: push request, sampled at the rising edge.
- `data_in`  input  `width`: push data, sampled with `write`.
- `read`  input  1: pop request, sampled at the rising edge.
- `data_out`  output  `width`: popped word, registered.
- `full`  output  1: `count == depth`.
- `empty`  output  1: `count == 0`.
- `count`  output  `addr+1`: current occupancy, 0..`depth`.
- `overflow`  output  1: one-cycle pulse, push rejected.
- `underflow`  output  1: one-cycle pulse, pop rejected.

## Operation
- Pointers:
  - `wr_ptr` and `rd_ptr` are `addr` bits wide.
  - Each increments by 1 on an accepted operation and wraps from `depth-1` to 0.
  - Occupancy is tracked in a separate `count` register of `addr+1` bits.
- Push acceptance: a push is accepted when `write` is high and either `!full`, or `full` with a pop accepted in the same cycle.
  - On accept: store `data_in` at `wr_ptr`, then increment `wr_ptr`.
- Pop acceptance: a pop is accepted when `read` is high and `!empty`.
  - On accept: `data_out` is loaded from `rd_ptr`, then `rd_ptr` increments.
- Count update:
  - Push only: +1.
  - Pop only: −1.
  - Both, or neither: unchanged.
- Rejected push (`write` while `full` with no accepted pop):
  - Data is dropped and the pointers are unchanged.
  - `overflow` pulses high for one cycle.
- Rejected pop (`read` while `empty`):
  - `data_out` holds its value.
  - `underflow` pulses high for one cycle.
- Simultaneous `write` and `read` while `empty`: the push is accepted, the pop is rejected, `underflow` pulses and `count` becomes 1.
- Simultaneous `write` and `read` while `full`: both are accepted and `count` stays at `depth`.
- `full` and `empty` are registered, updated in the same cycle as `count`, and are never both high.
- Reset values (`reset` low, takes effect immediately, asynchronously):
  - Pointers = 0, `count` = 0.
  - `data_out` = 0.
  - `empty` = 1, `full` = 0.
  - `overflow` = 0, `underflow` = 0.
  - RAM contents are not cleared, are undefined after reset, and are never exposed.
- Reset asserted mid-operation aborts any in-flight push or pop. The first accepted push after reset writes address 0.

## Timing
- Push: data is written at edge N. `count`, `empty` and `full` reflect the push after edge N.
- Pop: with `read` sampled at edge N, `data_out` is valid after edge N; latency is 1 cycle from request to data.
- Write-to-read visibility: a word pushed at edge N can be popped at edge N+1 at the earliest, giving a first-word fall-through of 2 cycles.
- `overflow` and `underflow` are high for exactly the cycle following the rejected request.
- There is no combinational path from inputs to outputs.
- Stimulus is driven on the falling edge of `clk`, matching lab bench practice.

## Structure
- Shared header `fifo_defs`: default `width`, `depth` and `addr` constants, plus the rule `depth == 1<<addr`.
- Sub-module: the existing `dual_ram` provides storage.
  - Write port is driven by `wr_ptr` and the accepted push.
  - Read port is driven by `rd_ptr` and the accepted pop.
  - The FIFO adds only control, pointers and flags.

## Test plan
- Reset, then no traffic → `empty`=1, `full`=0, `count`=0, `data_out`=0.
- Push 0x11, 0x22, 0x33, then pop ×3 → `data_out` = 0x11, 0x22, 0x33 on successive cycles; `empty`=1 afterwards.
- Push 16 random bytes → `full`=1, `count`=16. A 17th push (0xAA) → `overflow` pulses and `count`=16. Pop 16 → all original bytes out in order; 0xAA never appears.
- Pop while `empty` → `underflow` pulses and `data_out` is unchanged. Push and pop together while `empty` → `count`=1, `underflow`=1.
- Fill to 16, then push and pop together for 20 cycles → `count` stays 16, output order is preserved, and the pointers wrap past 15→0.
- Push 5 words, then assert `reset` low mid-cycle → outputs return to reset values immediately. After release, push 0x5A then pop → `data_out`=0x5A.

Source files
------------

// File: rtl/sync_fifo_pkg.sv
// Shared FIFO defaults. The depth must always equal 1 << addr so the pointers
// can wrap by simply overflowing.
package sync_fifo_pkg;

    localparam int FIFO_WIDTH = 8;
    localparam int FIFO_ADDR  = 4;
    localparam int FIFO_DEPTH = 1 << FIFO_ADDR;

endpackage

// File: rtl/sync_fifo_dual_ram.sv
// Dual-port RAM: one write port and one registered read port that holds
// its output unless a read is enabled.
module sync_fifo_dual_ram #(
    parameter int width = 8,
    parameter int addr  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [addr-1:0]  waddr,
    input  logic [width-1:0] wdata,
    input  logic             re,
    input  logic [addr-1:0]  raddr,
    output logic [width-1:0] rdata
);

    logic [width-1:0] mem_q [2**addr];
    logic [width-1:0] rdata_q, rdata_d;

    // Storage is never reset; only the output register has a defined reset value.
    always_ff @(posedge clk) begin
        if (we) mem_q[waddr] <= wdata;
    end

    always_comb begin
        rdata_d = rdata_q;
        if (re) rdata_d = mem_q[raddr];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rdata_q <= '0;
        else        rdata_q <= rdata_d;
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO: pointers, occupancy and flags around the dual-port RAM.
// All outputs are registered.
module sync_fifo
    import sync_fifo_pkg::*;
#(
    parameter int width = FIFO_WIDTH,
    parameter int depth = FIFO_DEPTH,
    parameter int addr  = FIFO_ADDR
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             write,
    input  logic [width-1:0] data_in,
    input  logic             read,
    output logic [width-1:0] data_out,
    output logic             full,
    output logic             empty,
    output logic [addr:0]    count,
    output logic             overflow,
    output logic             underflow
);

    localparam logic [addr:0] depth_cnt = (addr+1)'(depth);

    logic [addr-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [addr:0]   count_q, count_d;
    logic            full_q, full_d, empty_q, empty_d;
    logic            overflow_q, overflow_d, underflow_q, underflow_d;
    logic            push_ok, pop_ok;

    always_comb begin
        pop_ok      = read && !empty_q;
        // A full FIFO still takes a push when a pop frees a slot in the same cycle.
        push_ok     = write && (!full_q || pop_ok);
        wr_ptr_d    = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d    = pop_ok  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d     = count_q;
        if (push_ok && !pop_ok)      count_d = count_q + 1'b1;
        else if (pop_ok && !push_ok) count_d = count_q - 1'b1;
        full_d      = (count_d == depth_cnt);
        empty_d     = (count_d == '0);
        overflow_d  = write && !push_ok;
        underflow_d = read && !pop_ok;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            full_q      <= 1'b0;
            empty_q     <= 1'b1;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            full_q      <= full_d;
            empty_q     <= empty_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    sync_fifo_dual_ram #(
        .width (width),
        .addr  (addr)
    ) u_ram (
        .clk   (clk),
        .rst_n (reset),
        .we    (push_ok),
        .waddr (wr_ptr_q),
        .wdata (data_in),
        .re    (pop_ok),
        .raddr (rd_ptr_q),
        .rdata (data_out)
    );

    assign full      = full_q;
    assign empty     = empty_q;
    assign count     = count_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

endmodule

// File: tb/tb_sync_fifo.sv
// Bench for sync_fifo: directed vector table, hand-written corner sequences and
// random traffic, all checked against a queue-based reference model.
module tb_sync_fifo;

    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic       write;
    logic [7:0] data_in;
    logic       read;
    logic [7:0] data_out;
    logic       full, empty, overflow, underflow;
    logic [4:0] count;

    int checks = 0;
    int errors = 0;

    byte unsigned mq[$];
    byte unsigned m_dout;
    bit           m_ovf, m_udf;

    typedef struct {
        bit       w;
        bit [7:0] d;
        bit       r;
        bit [7:0] exp_dout;
        int       exp_cnt;
        bit       exp_ovf;
        bit       exp_udf;
    } vec_t;

    vec_t tbl[10];

    sync_fifo dut (
        .clk       (clk),
        .reset     (reset),
        .write     (write),
        .data_in   (data_in),
        .read      (read),
        .data_out  (data_out),
        .full      (full),
        .empty     (empty),
        .count     (count),
        .overflow  (overflow),
        .underflow (underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_dout = 8'h00;
        m_ovf  = 1'b0;
        m_udf  = 1'b0;
    endtask

    // Behavioural rules: a pop needs a stored word; a push needs room, where a
    // same-cycle pop counts as making room.
    task automatic model_apply(input bit w, input byte unsigned d, input bit r);
        bit pop_ok, push_ok;
        pop_ok  = r && (mq.size() != 0);
        push_ok = w && ((mq.size() < DEPTH) || pop_ok);
        if (pop_ok)  m_dout = mq.pop_front();
        if (push_ok) mq.push_back(d);
        m_ovf = w && !push_ok;
        m_udf = r && !pop_ok;
    endtask

    task automatic chk_all();
        chk("count",     int'(count),     mq.size());
        chk("full",      int'(full),      int'(mq.size() == DEPTH));
        chk("empty",     int'(empty),     int'(mq.size() == 0));
        chk("data_out",  int'(data_out),  int'(m_dout));
        chk("overflow",  int'(overflow),  int'(m_ovf));
        chk("underflow", int'(underflow), int'(m_udf));
    endtask

    task automatic step(input bit w, input byte unsigned d, input bit r);
        @(negedge clk);
        write   = w;
        data_in = d;
        read    = r;
        model_apply(w, d, r);
        @(posedge clk);
        #1;
        chk_all();
    endtask

    initial begin
        reset   = 1'b0;
        write   = 1'b0;
        read    = 1'b0;
        data_in = 8'h00;
        model_reset();

        tbl[0] = '{1'b1, 8'h11, 1'b0, 8'h00, 1, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 8'h22, 1'b0, 8'h00, 2, 1'b0, 1'b0};
        tbl[2] = '{1'b1, 8'h33, 1'b0, 8'h00, 3, 1'b0, 1'b0};
        tbl[3] = '{1'b0, 8'h00, 1'b1, 8'h11, 2, 1'b0, 1'b0};
        tbl[4] = '{1'b0, 8'h00, 1'b1, 8'h22, 1, 1'b0, 1'b0};
        tbl[5] = '{1'b0, 8'h00, 1'b1, 8'h33, 0, 1'b0, 1'b0};
        tbl[6] = '{1'b0, 8'h00, 1'b1, 8'h33, 0, 1'b0, 1'b1};
        tbl[7] = '{1'b0, 8'h00, 1'b0, 8'h33, 0, 1'b0, 1'b0};
        tbl[8] = '{1'b1, 8'h44, 1'b1, 8'h33, 1, 1'b0, 1'b1};
        tbl[9] = '{1'b0, 8'h00, 1'b1, 8'h44, 0, 1'b0, 1'b0};

        repeat (2) @(posedge clk);
        #1;
        chk("rst_count", int'(count), 0);
        chk("rst_empty", int'(empty), 1);
        chk("rst_full",  int'(full),  0);
        chk("rst_dout",  int'(data_out), 0);
        chk("rst_ovf",   int'(overflow), 0);
        chk("rst_udf",   int'(underflow), 0);
        @(negedge clk);
        reset = 1'b1;
        step(1'b0, 8'h00, 1'b0);

        // Directed vectors: basic order, underflow, push+pop while empty.
        for (int i = 0; i < 10; i++) begin
            step(tbl[i].w, tbl[i].d, tbl[i].r);
            chk($sformatf("tbl%0d_dout", i), int'(data_out),  int'(tbl[i].exp_dout));
            chk($sformatf("tbl%0d_cnt", i),  int'(count),     tbl[i].exp_cnt);
            chk($sformatf("tbl%0d_ovf", i),  int'(overflow),  int'(tbl[i].exp_ovf));
            chk($sformatf("tbl%0d_udf", i),  int'(underflow), int'(tbl[i].exp_udf));
        end

        // Fill, overflow with 0xAA, then drain in order.
        for (int i = 0; i < DEPTH; i++) step(1'b1, 8'($urandom_range(0, 8'hA9)), 1'b0);
        chk("fill_full", int'(full), 1);
        chk("fill_count", int'(count), 16);
        step(1'b1, 8'hAA, 1'b0);
        chk("ovf_pulse", int'(overflow), 1);
        chk("ovf_count", int'(count), 16);
        step(1'b0, 8'h00, 1'b0);
        chk("ovf_clear", int'(overflow), 0);
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b0, 8'h00, 1'b1);
            if (data_out == 8'hAA) chk("aa_leak", int'(data_out), -1);
        end
        chk("drain_empty", int'(empty), 1);

        // Full with simultaneous push/pop: occupancy holds, pointers wrap.
        for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(i + 8'h80), 1'b0);
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 8'($urandom), 1'b1);
            chk("wrap_count", int'(count), 16);
        end
        for (int i = 0; i < DEPTH; i++) step(1'b0, 8'h00, 1'b1);

        // Asynchronous reset in the middle of traffic.
        for (int i = 0; i < 5; i++) step(1'b1, 8'(i + 1), 1'b0);
        @(negedge clk);
        write = 1'b0;
        read  = 1'b0;
        #2 reset = 1'b0;
        #1;
        model_reset();
        chk("arst_count", int'(count), 0);
        chk("arst_empty", int'(empty), 1);
        chk("arst_full",  int'(full),  0);
        chk("arst_dout",  int'(data_out), 0);
        @(negedge clk);
        reset = 1'b1;
        step(1'b1, 8'h5A, 1'b0);
        step(1'b0, 8'h00, 1'b1);
        chk("post_rst_dout", int'(data_out), 8'h5A);

        // Random traffic with phases biased towards filling and draining.
        for (int p = 0; p < 8; p++) begin
            int wp;
            int rp;
            wp = (p % 2 == 0) ? 80 : 25;
            rp = (p % 2 == 0) ? 25 : 80;
            for (int i = 0; i < 50; i++)
                step(1'($urandom_range(0, 99) < wp), 8'($urandom), 1'($urandom_range(0, 99) < rp));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
